pool_2: RTL and testbench

- Max-pooling stage directly downstream of conv_2 in the LeNet datapath.
- Reads the 16 conv_2 output feature maps (10x10 each) from the conv_2 result BRAM through a read-only port.
- Applies non-overlapping 2x2 max pooling and writes 16 maps of 5x5 into the pool_2 result BRAM.
- Raises pool_2_finish for the top-level sequencer, which then starts the FC stage.

---
 rtl/lenet_pkg.sv | 21 ++
 rtl/max4_acc.sv | 65 ++++++
 rtl/pool_2.sv | 226 ++++++++++++++++++++++
 tb/tb_pool_2.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet constants and types used by the pooling stages.
package lenet_pkg;

  // Signed fixed-point sample width and per-layer dimensions (conv_2 -> pool_2).
  localparam int DW      = 16;
  localparam int FM_NUM  = 16;
  localparam int IN_DIM  = 10;
  localparam int OUT_DIM = 5;

  // conv_2 result BRAM holds 1600 samples, pool_2 result BRAM holds 400.
  localparam int AW_RD = 11;
  localparam int AW_WR = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_state_t;

endpackage

// File: rtl/max4_acc.sv
// Running max over a 2x2 window, fed one q-tagged sample per cycle.
// q=0 loads, q=1..3 keep the signed maximum (ties keep the held value).
// The q=3 result leaves through a one-cycle registered output with its tag.
module max4_acc #(
  parameter int DW = 16,
  parameter int TW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [1:0]    in_q,
  input  logic [DW-1:0] in_data,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [TW-1:0] out_tag
);

  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] cand;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [TW-1:0] out_tag_q, out_tag_d;

  // Next max and the one-shot result emitted with the window's last sample
  always_comb begin
    cand = max_q;
    if ((in_q == 2'd0) || ($signed(in_data) > $signed(max_q))) begin
      cand = in_data;
    end
    max_d       = max_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_tag_d   = '0;
    if (in_valid && !flush) begin
      max_d = cand;
      if (in_q == 2'd3) begin
        out_valid_d = 1'b1;
        out_data_d  = cand;
        out_tag_d   = in_tag;
      end
    end
  end

  // Accumulator and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: rtl/pool_2.sv
// pool_2: 2x2/stride-2 max pooling of the 16 conv_2 maps (10x10 -> 5x5).
// Issues one conv BRAM read per cycle, tags it with its window position,
// and writes one pooled result every 4 cycles into the pool_2 BRAM.
module pool_2 #(
  parameter int DW      = lenet_pkg::DW,
  parameter int FM_NUM  = lenet_pkg::FM_NUM,
  parameter int IN_DIM  = lenet_pkg::IN_DIM,
  parameter int OUT_DIM = lenet_pkg::OUT_DIM,
  parameter int RD_LAT  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pool_2_en,
  output logic                       conv_bram_en,
  output logic [lenet_pkg::AW_RD-1:0] conv_bram_addr,
  input  logic [DW-1:0]              conv_bram_dout,
  output logic                       pool_bram_we,
  output logic [lenet_pkg::AW_WR-1:0] pool_bram_addr,
  output logic [DW-1:0]              pool_bram_din,
  output logic                       pool_2_finish
);

  import lenet_pkg::*;

  localparam int FMW = $clog2(FM_NUM);
  localparam int OW  = $clog2(OUT_DIM);
  localparam logic [AW_WR-1:0] LAST_WR = AW_WR'(FM_NUM * OUT_DIM * OUT_DIM - 1);

  pool_state_t      state_q, state_d;
  logic             en_dly_q, en_dly_d;
  logic [FMW-1:0]   fm_q, fm_d;
  logic [OW-1:0]    r_q, r_d;
  logic [OW-1:0]    c_q, c_d;
  logic [1:0]       q_q, q_d;
  logic             rd_en_q, rd_en_d;
  logic [AW_RD-1:0] rd_addr_q, rd_addr_d;
  logic             finish_q, finish_d;
  logic             en_p;
  logic             last_rd;
  logic             flush;

  // Tag pipeline that travels alongside the BRAM read latency
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [1:0]        pq_q [RD_LAT];
  logic [1:0]        pq_d [RD_LAT];
  logic [AW_WR-1:0]  pa_q [RD_LAT];
  logic [AW_WR-1:0]  pa_d [RD_LAT];

  logic             acc_valid;
  logic [AW_WR-1:0] acc_tag;
  logic [DW-1:0]    acc_data;

  // fm*IN_DIM^2 + (2r+dy)*IN_DIM + 2c+dx, with (dy,dx) = q[1:0]
  function automatic logic [AW_RD-1:0] rd_addr_f(input logic [FMW-1:0] fm,
                                                  input logic [OW-1:0] r,
                                                  input logic [OW-1:0] c,
                                                  input logic [1:0] q);
    logic [AW_RD-1:0] row;
    logic [AW_RD-1:0] col;
    row = AW_RD'({r, 1'b0}) + AW_RD'(q[1]);
    col = AW_RD'({c, 1'b0}) + AW_RD'(q[0]);
    return AW_RD'(fm) * AW_RD'(IN_DIM * IN_DIM) + row * AW_RD'(IN_DIM) + col;
  endfunction

  // fm*OUT_DIM^2 + r*OUT_DIM + c
  function automatic logic [AW_WR-1:0] wr_addr_f(input logic [FMW-1:0] fm,
                                                  input logic [OW-1:0] r,
                                                  input logic [OW-1:0] c);
    return AW_WR'(fm) * AW_WR'(OUT_DIM * OUT_DIM) + AW_WR'(r) * AW_WR'(OUT_DIM)
           + AW_WR'(c);
  endfunction

  // FSM next state, read-order counters and registered read/finish outputs.
  // Counters always hold the position of the read presented on the port.
  always_comb begin
    en_p     = pool_2_en & ~en_dly_q;
    last_rd  = (fm_q == FMW'(FM_NUM - 1)) && (r_q == OW'(OUT_DIM - 1)) &&
               (c_q == OW'(OUT_DIM - 1)) && (q_q == 2'd3);
    en_dly_d = pool_2_en;
    state_d  = state_q;
    fm_d     = fm_q;
    r_d      = r_q;
    c_d      = c_q;
    q_d      = q_q;
    flush    = 1'b0;
    if (en_p) begin
      state_d = RUN;
      fm_d    = '0;
      r_d     = '0;
      c_d     = '0;
      q_d     = '0;
      flush   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (!pool_2_en) begin
            state_d = IDLE;
            flush   = 1'b1;
          end else if (last_rd) begin
            state_d = DRAIN;
            fm_d    = '0;
            r_d     = '0;
            c_d     = '0;
            q_d     = '0;
          end else begin
            q_d = q_q + 2'd1;
            if (q_q == 2'd3) begin
              if (c_q == OW'(OUT_DIM - 1)) begin
                c_d = '0;
                if (r_q == OW'(OUT_DIM - 1)) begin
                  r_d  = '0;
                  fm_d = fm_q + FMW'(1);
                end else begin
                  r_d = r_q + OW'(1);
                end
              end else begin
                c_d = c_q + OW'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (!pool_2_en) begin
            state_d = IDLE;
            flush   = 1'b1;
          end else if (acc_valid && (acc_tag == LAST_WR)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (!pool_2_en) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    rd_en_d   = (state_d == RUN);
    rd_addr_d = rd_en_d ? rd_addr_f(fm_d, r_d, c_d, q_d) : '0;
    finish_d  = (state_d == DONE);
  end

  // FSM, counters and registered read/finish outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      en_dly_q  <= 1'b0;
      fm_q      <= '0;
      r_q       <= '0;
      c_q       <= '0;
      q_q       <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_dly_q  <= en_dly_d;
      fm_q      <= fm_d;
      r_q       <= r_d;
      c_q       <= c_d;
      q_q       <= q_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      finish_q  <= finish_d;
    end
  end

  // Shift the read tag RD_LAT stages so it lines up with conv_bram_dout;
  // an abort or restart drops everything in flight
  always_comb begin
    pv_d[0] = rd_en_q & ~flush;
    pq_d[0] = q_q;
    pa_d[0] = wr_addr_f(fm_q, r_q, c_q);
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1] & ~flush;
      pq_d[i] = pq_q[i-1];
      pa_d[i] = pa_q[i-1];
    end
  end

  // Tag pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pq_q[i] <= '0;
        pa_q[i] <= '0;
      end
    end else begin
      pv_q <= pv_d;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pq_q[i] <= pq_d[i];
        pa_q[i] <= pa_d[i];
      end
    end
  end

  max4_acc #(
    .DW(DW),
    .TW(AW_WR)
  ) u_max4_acc (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (pv_q[RD_LAT-1]),
    .in_q     (pq_q[RD_LAT-1]),
    .in_data  (conv_bram_dout),
    .in_tag   (pa_q[RD_LAT-1]),
    .out_valid(acc_valid),
    .out_data (acc_data),
    .out_tag  (acc_tag)
  );

  assign conv_bram_en   = rd_en_q;
  assign conv_bram_addr = rd_addr_q;
  assign pool_bram_we   = acc_valid;
  assign pool_bram_addr = acc_tag;
  assign pool_bram_din  = acc_data;
  assign pool_2_finish  = finish_q;

endmodule

// File: tb/tb_pool_2.sv
// Bench for pool_2: two instances (RD_LAT=1 and RD_LAT=2) share one conv
// BRAM image; expected writes are queued per instance and popped on each write.
module tb_pool_2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en    [2];
  logic        rd_en [2];
  logic [10:0] rd_a  [2];
  logic [15:0] dout  [2];
  logic        we    [2];
  logic [8:0]  wa    [2];
  logic [15:0] wd    [2];
  logic        fin   [2];
  logic [15:0] d1_s;

  logic [15:0] mem [2048];
  logic [24:0] q0 [$];
  logic [24:0] q1 [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int rd_cnt [2];
  int wr_cnt [2];
  int rd_start_cyc [2];
  int rd_start_addr [2];
  int wr0_cyc [2];
  int wr_last_cyc [2];
  int fin_rise_cyc [2];
  logic rd_prev [2];
  logic fin_prev [2];
  int wcyc [2][400];
  logic [15:0] wdat0 [400];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // conv BRAM models: 1-cycle for u0, 2-cycle for u1
  always @(posedge clk) begin
    dout[0] <= mem[rd_a[0]];
    d1_s    <= mem[rd_a[1]];
    dout[1] <= d1_s;
  end

  pool_2 u0 (
    .clk(clk), .rst(rst), .pool_2_en(en[0]),
    .conv_bram_en(rd_en[0]), .conv_bram_addr(rd_a[0]), .conv_bram_dout(dout[0]),
    .pool_bram_we(we[0]), .pool_bram_addr(wa[0]), .pool_bram_din(wd[0]),
    .pool_2_finish(fin[0])
  );

  pool_2 #(.RD_LAT(2)) u1 (
    .clk(clk), .rst(rst), .pool_2_en(en[1]),
    .conv_bram_en(rd_en[1]), .conv_bram_addr(rd_a[1]), .conv_bram_dout(dout[1]),
    .pool_bram_we(we[1]), .pool_bram_addr(wa[1]), .pool_bram_din(wd[1]),
    .pool_2_finish(fin[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] win_max(input int fm, input int r, input int c);
    logic signed [15:0] m;
    logic signed [15:0] v;
    m = '0;
    for (int q = 0; q < 4; q++) begin
      v = mem[fm*100 + (2*r + q/2)*10 + 2*c + q%2];
      if (q == 0 || v > m) m = v;
    end
    return m;
  endfunction

  task automatic push_pass(input int d);
    logic [24:0] e;
    for (int fm = 0; fm < 16; fm++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          e = {9'(fm*25 + r*5 + c), win_max(fm, r, c)};
          if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
  endtask

  task automatic wait_fin(input int d, input int budget);
    for (int i = 0; i < budget && !fin[d]; i++) step();
    chk($sformatf("fin%0d_timeout", d), 32'(fin[d]), 1);
  endtask

  task automatic ramp_mem();
    for (int a = 0; a < 2048; a++) mem[a] = 16'(a);
  endtask

  // Monitor: read/finish bookkeeping and scoreboard pop on every write
  always @(negedge clk) begin
    logic [24:0] e;
    logic has;
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d]) begin
        if (!rd_prev[d]) begin
          rd_start_cyc[d]  = cyc;
          rd_start_addr[d] = 32'(rd_a[d]);
        end
        rd_cnt[d]++;
      end
      rd_prev[d] = rd_en[d];
      if (fin[d] && !fin_prev[d]) fin_rise_cyc[d] = cyc;
      fin_prev[d] = fin[d];
      if (we[d]) begin
        wr_cnt[d]++;
        if (wa[d] == 9'd0) wr0_cyc[d] = cyc;
        if (wa[d] == 9'd399) wr_last_cyc[d] = cyc;
        if (wa[d] < 9'd400) begin
          wcyc[d][wa[d]] = cyc;
          if (d == 0) wdat0[wa[d]] = wd[d];
        end
        has = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
        chk($sformatf("wr%0d_expected", d), 32'(has), 1);
        if (has) begin
          if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk($sformatf("wr%0d_addr", d), 32'(wa[d]), 32'(e[24:16]));
          chk($sformatf("wr%0d_data", d), 32'(wd[d]), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rb [2];
    int wb [2];
    int held;
    int bad;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; rd_cnt[d] = 0; wr_cnt[d] = 0; rd_prev[d] = 1'b0; fin_prev[d] = 1'b0;
      rd_start_cyc[d] = -1; rd_start_addr[d] = -1; wr0_cyc[d] = -1;
      wr_last_cyc[d] = -1; fin_rise_cyc[d] = -1;
    end
    ramp_mem();
    #1 rst = 1'b0;
    repeat (3) step();

    // Reset state
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_rd_en", d), 32'(rd_en[d]), 0);
      chk($sformatf("rst%0d_rd_addr", d), 32'(rd_a[d]), 0);
      chk($sformatf("rst%0d_we", d), 32'(we[d]), 0);
      chk($sformatf("rst%0d_wr_addr", d), 32'(wa[d]), 0);
      chk($sformatf("rst%0d_din", d), 32'(wd[d]), 0);
      chk($sformatf("rst%0d_fin", d), 32'(fin[d]), 0);
    end
    rst = 1'b1;
    repeat (2) step();

    // Ramp on both latencies in lockstep
    push_pass(0);
    push_pass(1);
    for (int d = 0; d < 2; d++) begin rb[d] = rd_cnt[d]; wb[d] = wr_cnt[d]; end
    en[0] = 1'b1;
    en[1] = 1'b1;
    wait_fin(0, 2000);
    wait_fin(1, 20);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ramp%0d_reads", d), 32'(rd_cnt[d] - rb[d]), 1600);
      chk($sformatf("ramp%0d_writes", d), 32'(wr_cnt[d] - wb[d]), 400);
      chk($sformatf("ramp%0d_first_rd_addr", d), 32'(rd_start_addr[d]), 0);
      chk($sformatf("ramp%0d_first_wr_lat", d), 32'(wr0_cyc[d] - rd_start_cyc[d]), 32'(5 + d));
      chk($sformatf("ramp%0d_fin_after_399", d), 32'(fin_rise_cyc[d] - wr_last_cyc[d]), 1);
      chk($sformatf("ramp%0d_duration", d), 32'(wr_last_cyc[d] - rd_start_cyc[d] + 1), 32'(1602 + d));
    end
    chk("ramp0_queue_left", 32'(q0.size()), 0);
    chk("ramp1_queue_left", 32'(q1.size()), 0);
    bad = 0;
    for (int k = 0; k < 400; k++) if (wcyc[1][k] - wcyc[0][k] != 1) bad++;
    chk("lat2_shift_mismatches", 32'(bad), 0);

    // Finish held while enable stays high, cleared the cycle after it drops
    held = 0;
    repeat (50) begin
      step();
      if (fin[0] && fin[1]) held++;
    end
    chk("fin_hold_cycles", 32'(held), 50);
    en[0] = 1'b0;
    en[1] = 1'b0;
    step();
    chk("fin0_clear", 32'(fin[0]), 0);
    chk("fin1_clear", 32'(fin[1]), 0);
    chk("idle0_rd_en", 32'(rd_en[0]), 0);
    step();

    // Signed compare and ties
    mem[0] = 16'hFFFB; mem[1] = 16'hFFFD; mem[10] = 16'hFFFD; mem[11] = 16'h8000;
    mem[2] = 16'h8000; mem[3] = 16'h8000; mem[12] = 16'h8000; mem[13] = 16'h8000;
    push_pass(0);
    en[0] = 1'b1;
    wait_fin(0, 2000);
    chk("signed_queue_left", 32'(q0.size()), 0);
    chk("signed_win0", 32'(wdat0[0]), 32'h0000FFFD);
    chk("signed_win1_all_min", 32'(wdat0[1]), 32'h00008000);
    en[0] = 1'b0;
    step();
    ramp_mem();

    // Abort after 700 reads, then restart from the beginning
    push_pass(0);
    rb[0] = rd_cnt[0];
    wb[0] = wr_cnt[0];
    en[0] = 1'b1;
    for (int i = 0; i < 1000 && (rd_cnt[0] - rb[0]) < 700; i++) step();
    chk("abort_reads_at_drop", 32'(rd_cnt[0] - rb[0]), 700);
    en[0] = 1'b0;
    step();
    chk("abort_rd_en", 32'(rd_en[0]), 0);
    chk("abort_we", 32'(we[0]), 0);
    repeat (20) step();
    // windows 0..173 complete their write before the drop is sampled
    chk("abort_writes", 32'(wr_cnt[0] - wb[0]), 174);
    chk("abort_reads_total", 32'(rd_cnt[0] - rb[0]), 700);
    q0.delete();
    push_pass(0);
    wb[0] = wr_cnt[0];
    en[0] = 1'b1;
    wait_fin(0, 2000);
    chk("restart_first_rd_addr", 32'(rd_start_addr[0]), 0);
    chk("restart_first_wr_lat", 32'(wr0_cyc[0] - rd_start_cyc[0]), 5);
    chk("restart_writes", 32'(wr_cnt[0] - wb[0]), 400);
    chk("restart_queue_left", 32'(q0.size()), 0);
    en[0] = 1'b0;
    step();

    // Asynchronous reset during DRAIN
    push_pass(0);
    rb[0] = rd_cnt[0];
    wb[0] = wr_cnt[0];
    en[0] = 1'b1;
    for (int i = 0; i < 2000 && (rd_cnt[0] - rb[0]) < 1600; i++) step();
    step();
    #2;
    rst = 1'b0;
    en[0] = 1'b0;
    #1;
    chk("arst_rd_en", 32'(rd_en[0]), 0);
    chk("arst_rd_addr", 32'(rd_a[0]), 0);
    chk("arst_we", 32'(we[0]), 0);
    chk("arst_wr_addr", 32'(wa[0]), 0);
    chk("arst_din", 32'(wd[0]), 0);
    chk("arst_fin", 32'(fin[0]), 0);
    chk("arst_writes_before", 32'(wr_cnt[0] - wb[0]), 399);
    q0.delete();
    repeat (2) step();
    rst = 1'b1;
    bad = 0;
    repeat (30) begin
      step();
      if (fin[0] || we[0] || rd_en[0]) bad++;
    end
    chk("arst_quiet_after_release", 32'(bad), 0);
    chk("arst_writes_after", 32'(wr_cnt[0] - wb[0]), 399);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
